// File: rtl/sha256_pkg.sv
// sha256_pkg: shared SHA-256 word type, sigma rotate/shift constants and the small-sigma-1 reference function
package sha256_pkg;
   typedef logic [31:0] word_t;
   localparam int SIG0_ROT_A = 7;
   localparam int SIG0_ROT_B = 18;
   localparam int SIG0_SHR   = 3;
   localparam int SIG1_ROT_A = 17;
   localparam int SIG1_ROT_B = 19;
   localparam int SIG1_SHR   = 10;
   function automatic word_t small_sigma1(input word_t x);
      return ((x >> SIG1_ROT_A) | (x << (32 - SIG1_ROT_A))) ^
             ((x >> SIG1_ROT_B) | (x << (32 - SIG1_ROT_B))) ^
             (x >> SIG1_SHR);
   endfunction
endpackage

// File: rtl/sha256_sigma1_comb.sv
// sha256_sigma1_comb: purely combinational SHA-256 small sigma-1
//   word_i    : operand x (W[t-2])
//   sigma1_o  : ROTR17(x) ^ ROTR19(x) ^ SHR10(x)
module sha256_sigma1_comb
   import sha256_pkg::*;
(
   input  logic [31:0] word_i,
   output logic [31:0] sigma1_o
);
   assign sigma1_o = small_sigma1(word_i);
endmodule

// File: rtl/sha256_sigma1.sv
// sha256_sigma1: registered SHA-256 small sigma-1, one-cycle latency, one word per clock
//   clock         : rising-edge clock
//   reset         : synchronous, active-low; clears the output register
//   word          : operand x (W[t-2])
//   sigma1_output : sigma1 of the word sampled at the previous edge
// Optional macro SHA256_SIGMA1_ASSERT_EN adds a simulation-only check against small_sigma1.
module sha256_sigma1
   import sha256_pkg::*;
(
   input  logic        clock,
   input  logic        reset,
   input  logic [31:0] word,
   output logic [31:0] sigma1_output
);
   word_t sigma1_d, sigma1_q;
   sha256_sigma1_comb u_comb (
      .word_i   (word),
      .sigma1_o (sigma1_d)
   );
   always_ff @(posedge clock) sigma1_q <= reset ? sigma1_d : '0;
   assign sigma1_output = sigma1_q;
`ifdef SHA256_SIGMA1_ASSERT_EN
   // Output seen at this edge was loaded at the previous edge, so compare against
   // that edge's word, and only when reset was released there.
   word_t word_q;
   logic  valid_q;
   always_ff @(posedge clock) begin
      word_q  <= word;
      valid_q <= reset;
      if (valid_q && sigma1_q != small_sigma1(word_q))
         $error("sha256_sigma1: output %h, reference %h", sigma1_q, small_sigma1(word_q));
   end
`endif
endmodule

// File: tb/tb_sha256_sigma1.sv
// tb_sha256_sigma1: table-driven and sequence checks of the registered sigma-1 unit
module tb_sha256_sigma1;
   logic        clock = 1'b0;
   logic        reset;
   logic [31:0] word;
   logic [31:0] sigma1_output;
   int total = 0;
   int bad   = 0;

   sha256_sigma1 dut (
      .clock         (clock),
      .reset         (reset),
      .word          (word),
      .sigma1_output (sigma1_output)
   );

   always #5 clock = ~clock;

   typedef struct {
      logic [31:0] w;
      logic [31:0] exp;
      string       name;
   } vec_t;

   // Independent bit-level model of sigma-1.
   function automatic logic [31:0] model(input logic [31:0] x);
      logic [31:0] r;
      for (int i = 0; i < 32; i++)
         r[i] = x[(i + 17) % 32] ^ x[(i + 19) % 32] ^ (i < 22 ? x[(i + 10) % 32] : 1'b0);
      return r;
   endfunction

   task automatic step(input logic [31:0] w, input logic r);
      @(negedge clock);
      word  = w;
      reset = r;
      @(posedge clock);
      #1;
   endtask

   task automatic check(input string name, input logic [31:0] exp);
      total++;
      if (sigma1_output !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", name, sigma1_output, exp);
      end
   endtask

   initial begin
      vec_t vecs[5];
      logic [31:0] w;
      vecs[0] = '{32'h0000_0001, 32'h0000_A000, "one"};
      vecs[1] = '{32'h8000_0000, 32'h0020_5000, "msb"};
      vecs[2] = '{32'h0000_0000, 32'h0000_0000, "zero"};
      vecs[3] = '{32'hFFFF_FFFF, 32'h003F_FFFF, "ones"};
      vecs[4] = '{32'hABCD_EF01, 32'h4A4A_13E4, "abcdef01"};
      reset = 1'b0;
      word  = 32'hABCD_EF01;
      step(32'hABCD_EF01, 1'b0);
      check("reset_edge1", 32'h0);
      step(32'hABCD_EF01, 1'b0);
      check("reset_edge2", 32'h0);
      step(32'hABCD_EF01, 1'b1);
      check("reset_release", 32'h4A4A_13E4);
      for (int i = 0; i < 5; i++) begin
         step(vecs[i].w, 1'b1);
         check(vecs[i].name, vecs[i].exp);
      end
      step(32'h0000_0001, 1'b1);
      check("stream0", 32'h0000_A000);
      step(32'h8000_0000, 1'b1);
      check("stream1", 32'h0020_5000);
      step(32'hABCD_EF01, 1'b1);
      check("stream2", 32'h4A4A_13E4);
      step(32'h0000_0001, 1'b1);
      check("pulse_pre", 32'h0000_A000);
      step(32'hABCD_EF01, 1'b0);
      check("pulse_low", 32'h0);
      step(32'hABCD_EF01, 1'b1);
      check("pulse_resume", 32'h4A4A_13E4);
      step(32'h8000_0000, 1'b1);
      check("pulse_next", 32'h0020_5000);
      for (int i = 0; i < 10000; i++) begin
         w = $urandom;
         step(w, 1'b1);
         check("random", model(w));
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
